// File: rtl/inta_sequencer_pkg.sv
// pic_8259_pkg: shared state encoding, counter width and INTA polarity for the acknowledge sequencer
package pic_8259_pkg;
  typedef enum logic [2:0] {IDLE, ACK1, GAP, ACK2, HOLD, COOL} inta_state_t;
  localparam int CNT_W = 4;
  localparam logic INTA_ASSERTED = 1'b0;
  localparam logic INTA_IDLE = 1'b1;
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction
endpackage

// File: rtl/inta_sequencer_if.sv
// inta_sequencer_if: PIC-facing acknowledge signals plus the vector handshake towards the core
interface inta_sequencer_if;
  logic       int_enable;
  logic       INT;
  logic [7:0] data_bus;
  logic       INTA;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       vector_ready;
  logic       busy;
  modport master (
    input  int_enable, INT, data_bus, vector_ready,
    output INTA, vector_out, vector_valid, busy
  );
  modport slave (
    output int_enable, INT, data_bus, vector_ready,
    input  INTA, vector_out, vector_valid, busy
  );
endinterface

// File: rtl/inta_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing the asynchronous INT into the clock domain
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  // shift the raw input through two flops; reset clears both
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {sync_q, meta_q} <= 2'b00;
    else {sync_q, meta_q} <= {meta_q, d};
  assign q = sync_q;
endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: drives the two-pulse INTA sequence and hands the captured vector to the core
module inta_sequencer
  import pic_8259_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input logic clock,
  input logic reset_n,
  inta_sequencer_if.master bus
);
  localparam logic [CNT_W-1:0] LOW_LD = cnt_load(INTA_LOW_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD = cnt_load(INTA_GAP_CYCLES);
  inta_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] vec_q, vec_d;
  logic inta_q, inta_d, valid_q, valid_d, busy_q, busy_d, req_q, req_d;
  logic int_s, done;
  sync_2ff u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (bus.INT),
    .q      (int_s)
  );
  assign done = cnt_q == '0;
  // next-state logic; req_q adds the cycle that puts the first INTA edge three edges after INT is sampled
  always_comb begin
    state_d = state_q;
    cnt_d = done ? cnt_q : cnt_q - 1'b1;
    vec_d = vec_q;
    valid_d = valid_q;
    req_d = int_s && bus.int_enable && !valid_q;
    case (state_q)
      IDLE: if (req_q) begin
        state_d = ACK1;
        cnt_d = LOW_LD;
      end
      ACK1: if (done) begin
        state_d = GAP;
        cnt_d = GAP_LD;
      end
      GAP: if (done) begin
        state_d = ACK2;
        cnt_d = LOW_LD;
      end
      ACK2: if (done) begin
        state_d = HOLD;
        vec_d = bus.data_bus;
        valid_d = 1'b1;
      end
      HOLD: if (valid_q && bus.vector_ready) begin
        state_d = COOL;
        cnt_d = GAP_LD;
        valid_d = 1'b0;
      end
      COOL: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inta_d = (state_d == ACK1 || state_d == ACK2) ? INTA_ASSERTED : INTA_IDLE;
    busy_d = state_d != IDLE;
  end
  // all state and outputs are registered so INTA and busy never glitch
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vec_q <= 8'h00;
      valid_q <= 1'b0;
      inta_q <= INTA_IDLE;
      busy_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      valid_q <= valid_d;
      inta_q <= inta_d;
      busy_q <= busy_d;
      req_q <= req_d;
    end
  assign bus.INTA = inta_q;
  assign bus.vector_out = vec_q;
  assign bus.vector_valid = valid_q;
  assign bus.busy = busy_q;
endmodule
